// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the register-file geometry, the source-index names and the
// {addr, data} entry that each source FIFO stores.
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t, DEPTH a power of two >= 2.
// Ports: clk, resetn (async, active low), push/din, pop/dout, full, empty,
// count. With WB_SCOREBOARD_EN defined it also exposes every storage slot
// (entries) and which slots currently hold live data (entry_vld).
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef WB_SCOREBOARD_EN
    ,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]         entry_vld
`endif
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read once count says it is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

`ifdef WB_SCOREBOARD_EN
    logic [AW-1:0] off;

    assign entries = mem;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_vld = '0;
        off       = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off          = AW'(j) - rptr;
            entry_vld[j] = ({1'b0, off} < count);
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges N_SRC write-back sources into the single
// register-file write port. Each source pushes {addr, data} into its own
// wb_fifo; a round-robin arbiter pops one head per cycle into registered
// rf_we/rf_waddr/rf_wdata. Writes to x0 consume a slot but never raise rf_we.
// Ports: clk, resetn (async, active low), src_valid/src_ready/src_addr/
// src_data per source (packed flat), rf_we/rf_waddr/rf_wdata, wb_pending.
// Optional feature macro: WB_SCOREBOARD_EN enables the per-register
// in-flight flags on wb_pending; otherwise wb_pending is tied to zero.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [REG_AW*N_SRC-1:0] src_addr,
    input  logic [REG_DW*N_SRC-1:0] src_data,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [REG_DW-1:0]       rf_wdata,
    output logic [31:0]             wb_pending
);

    localparam int PW = $clog2(N_SRC);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_SRC-1:0]            push;
    logic [N_SRC-1:0]            pop;
    logic [N_SRC-1:0]            full;
    logic [N_SRC-1:0]            empty;
    logic [N_SRC-1:0][CW-1:0]    cnt;
    wb_entry_t [N_SRC-1:0]       din;
    wb_entry_t [N_SRC-1:0]       head;
    logic [PW-1:0]               rr_ptr;
    logic [PW-1:0]               gnt_idx;
    logic                        gnt_vld;
    wb_entry_t                   gnt_entry;
    logic                        unused_cnt;

`ifdef WB_SCOREBOARD_EN
    wb_entry_t [DEPTH-1:0]       sb_ent [N_SRC];
    logic [DEPTH-1:0]            sb_vld [N_SRC];
`endif

    assign src_ready  = ~full;
    assign unused_cnt = ^cnt;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign push[i] = src_valid[i] & ~full[i];
        assign pop[i]  = gnt_vld && (gnt_idx == PW'(i));
        assign din[i]  = '{addr: src_addr[REG_AW*i +: REG_AW],
                           data: src_data[REG_DW*i +: REG_DW]};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .resetn   (resetn),
            .push     (push[i]),
            .din      (din[i]),
            .pop      (pop[i]),
            .dout     (head[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .count    (cnt[i])
`ifdef WB_SCOREBOARD_EN
            ,
            .entries  (sb_ent[i]),
            .entry_vld(sb_vld[i])
`endif
        );
    end

    // Round-robin pick: scan offsets from highest to lowest so the candidate
    // closest to rr_ptr (smallest offset) is the last one written and wins.
    always_comb begin
        int s;
        s       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            s = int'(rr_ptr) + k;
            if (s >= N_SRC) s = s - N_SRC;
            if (!empty[s]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(s);
            end
        end
    end

    assign gnt_entry = head[gnt_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt_vld) begin
            rr_ptr   <= (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + PW'(1);
            rf_we    <= (gnt_entry.addr != '0);
            rf_waddr <= gnt_entry.addr;
            rf_wdata <= gnt_entry.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        wb_pending = '0;
        for (int s = 0; s < N_SRC; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (sb_vld[s][j]) wb_pending[sb_ent[s][j].addr] = 1'b1;
            end
        end
        if (rf_we) wb_pending[rf_waddr] = 1'b1;
        wb_pending[0] = 1'b0;
    end
`else
    assign wb_pending = '0;
`endif

endmodule
